bcd_display_sched: RTL and testbench

BCD_DISPLAY_SCHED -- requirements
Module: bcd_display_sched

---
 rtl/bcd_pkg.sv | 34 +++
 rtl/bcd_dd_step.sv | 26 ++
 rtl/bcd_display_sched.sv | 185 ++++++++++++++++++
 tb/tb_bcd_display_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD display scheduler: FSM state encoding,
// datapath widths, the blank code and the digit formatting helper.
package bcd_pkg;

  localparam int BIN_W      = 12;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 16;
  localparam int ITER_W     = 4;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Pick the nibble shown for digit idx. With blanking enabled, a digit
  // above the ones position is blanked only when it and every digit
  // above it are zero, so interior zeros (e.g. 1000) stay visible.
  function automatic logic [3:0] display_nibble(input logic [BCD_W-1:0] val,
                                                input logic [1:0]       idx,
                                                input logic             blank_en);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (k >= int'(idx) && val[4*k +: 4] != 4'h0) upper_zero = 1'b0;
    end
    if (blank_en && idx != 2'd0 && upper_zero) return BLANK_CODE;
    return val[4*idx +: 4];
  endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble above 4, then
// shift {bcd, bin} left by one bit. Purely combinational.
module bcd_dd_step
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic [BIN_W-1:0] bin_o
);

  logic [BCD_W-1:0] adj;

  // Nibble correction followed by the joint left shift.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path before
    // any conditional update, so no latch can be inferred.
    adj = bcd_i;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_i[4*k +: 4] > 4'd4) adj[4*k +: 4] = bcd_i[4*k +: 4] + 4'd3;
    end
    bcd_o = {adj[BCD_W-2:0], bin_i[BIN_W-1]};
    bin_o = {bin_i[BIN_W-2:0], 1'b0};
  end

endmodule

// File: rtl/bcd_display_sched.sv
// Two-requester binary-to-BCD converter with round-robin arbitration and a
// 4-digit multiplexed display scanner. The conversion FSM and the scanner
// run independently; the scanner only reads the registered result.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// above the ones position (shown as 4'hF).
module bcd_display_sched
  import bcd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned BIN_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [BIN_W-1:0] bin0,
  input  logic [BIN_W-1:0] bin1,
  output logic [1:0]       ack,
  output logic             busy,
  output logic             src,
  output logic [3:0]       digit_sel,
  output logic [3:0]       digit_val
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZB_EN = 1'b1;
`else
  localparam logic LZB_EN = 1'b0;
`endif

  localparam int unsigned       CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(BIN_W - 1);

  // Conversion FSM and datapath state.
  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             prio_q, prio_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [BCD_W-1:0] result_q, result_d;
  logic             src_q, src_d;

  // Display scanner state.
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       digit_sel_q, digit_sel_d;
  logic [3:0]       digit_val_q, digit_val_d;

  logic             req_win;
  logic             scan_wrap;
  logic [BCD_W-1:0] step_bcd;
  logic [BIN_W-1:0] step_bin;

  // Single shared add-3-and-shift stage, fed from the working registers.
  bcd_dd_step u_step (
    .bcd_i (acc_q),
    .bin_i (shreg_q),
    .bcd_o (step_bcd),
    .bin_o (step_bin)
  );

  // Round-robin choice: contention goes to the pointer, otherwise to the
  // sole requester.
  assign req_win = (req == 2'b11) ? prio_q : req[1];

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (iter_q == ITER_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy spans grant through the ack cycle.
  always_comb begin
    ack  = 2'b00;
    busy = (state_q != IDLE);
    if (state_q == DONE) ack = grant_q ? 2'b10 : 2'b01;
  end

  // Conversion datapath next-state: grant/operand capture, iterations,
  // result publication.
  always_comb begin
    grant_d  = grant_q;
    prio_d   = prio_q;
    shreg_d  = shreg_q;
    acc_d    = acc_q;
    iter_d   = iter_q;
    result_d = result_q;
    src_d    = src_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = req_win;
          prio_d  = ~req_win;
          shreg_d = req_win ? bin1 : bin0;
        end
      end
      LOAD: begin
        acc_d  = '0;
        iter_d = '0;
      end
      SHIFT: begin
        acc_d   = step_bcd;
        shreg_d = step_bin;
        iter_d  = iter_q + 1'b1;
      end
      DONE: begin
        result_d = acc_q;
        src_d    = grant_q;
      end
      default: ;
    endcase
  end

  // Conversion datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q  <= 1'b0;
      prio_q   <= 1'b0;
      shreg_q  <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      result_q <= '0;
      src_q    <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      prio_q   <= prio_d;
      shreg_q  <= shreg_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      src_q    <= src_d;
    end
  end

  assign scan_wrap = (scan_cnt_q == SCAN_LAST);

  // Scanner next-state: digit enable and value change together on wrap
  // and then hold for the whole slot, so a new result never glitches a slot.
  always_comb begin
    scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    digit_sel_d = digit_sel_q;
    digit_val_d = digit_val_q;
    if (scan_wrap) begin
      idx_d       = idx_q + 2'd1;
      digit_sel_d = ~(4'b0001 << idx_d);
      digit_val_d = display_nibble(result_q, idx_d, LZB_EN);
    end
  end

  // Scanner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      idx_q       <= 2'd0;
      digit_sel_q <= 4'b1110;
      digit_val_q <= 4'h0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      digit_sel_q <= digit_sel_d;
      digit_val_q <= digit_val_d;
    end
  end

  assign src       = src_q;
  assign digit_sel = digit_sel_q;
  assign digit_val = digit_val_q;

endmodule

// File: tb/tb_bcd_display_sched.sv
// Directed self-checking bench for bcd_display_sched with a short scan
// period. Honours LEADING_ZERO_BLANK_EN for display expectations.
module tb_bcd_display_sched;

  localparam int SCAN_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [11:0] bin0, bin1;
  logic [1:0]  ack;
  logic        busy, src;
  logic [3:0]  digit_sel, digit_val;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_display_sched #(.SCAN_DIV(SCAN_DIV), .BIN_W(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .bin0      (bin0),
    .bin1      (bin1),
    .ack       (ack),
    .busy      (busy),
    .src       (src),
    .digit_sel (digit_sel),
    .digit_val (digit_val)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles from the IDLE cycle that first sees req (cycle 0) to ack.
  task automatic wait_ack(input string tag, input int start, input logic [1:0] exp_ack);
    int n;
    n = start;
    while (ack == 2'b00 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 14);
    check({tag, "_ack"}, ack, exp_ack);
    check({tag, "_busy_at_ack"}, busy, 1'b1);
  endtask

  // Collects one full scan round and checks the four displayed digits.
  task automatic read_display(input string tag, input logic [15:0] exp);
    logic [15:0] got;
    logic        bad;
    got = 'x;
    bad = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      case (digit_sel)
        4'b1110: got[3:0]   = digit_val;
        4'b1101: got[7:4]   = digit_val;
        4'b1011: got[11:8]  = digit_val;
        4'b0111: got[15:12] = digit_val;
        default: bad = 1'b1;
      endcase
    end
    check({tag, "_digits"}, got, exp);
    check({tag, "_sel_onehot"}, bad, 1'b0);
  endtask

  initial begin
    logic [3:0] prev_sel;
    logic [3:0] seq [4];
    int         n;
    logic       seen_ack;

    rst = 1'b1; req = 2'b00; bin0 = '0; bin1 = '0;
    tick(); tick();
    check("reset_ack", ack, 2'b00);
    check("reset_busy", busy, 1'b0);
    check("reset_src", src, 1'b0);
    check("reset_sel", digit_sel, 4'b1110);
    check("reset_val", digit_val, 4'h0);
    rst = 1'b0;

    // Single conversion of the largest operand.
    tick();
    bin0 = 12'd4095; req = 2'b01;
    wait_ack("c4095", 0, 2'b01);
    req = 2'b00;
    tick();
    check("c4095_ack_pulse", ack, 2'b00);
    check("c4095_busy_after", busy, 1'b0);
    check("c4095_src", src, 1'b0);
    read_display("c4095", 16'h4095);

    // Contention after reset: 0 first, then 1 back-to-back, then 0 again.
    rst = 1'b1; tick(); rst = 1'b0;
    bin0 = 12'd123; bin1 = 12'd987; req = 2'b11;
    wait_ack("rr_first", 0, 2'b01);
    req = 2'b10;
    tick();
    check("rr_gap_busy", busy, 1'b0);
    check("rr_first_src", src, 1'b0);
    wait_ack("rr_second", 0, 2'b10);
    req = 2'b00;
    tick();
    check("rr_second_src", src, 1'b1);
    read_display("rr_second", LZB ? 16'hF987 : 16'h0987);
    req = 2'b11;
    wait_ack("rr_third", 0, 2'b01);
    req = 2'b00;
    tick();
    read_display("rr_third", LZB ? 16'hF123 : 16'h0123);

    // Leave src=1 so the mid-conversion reset has something to clear.
    bin1 = 12'd7; req = 2'b10;
    wait_ack("pre_abort", 0, 2'b10);
    req = 2'b00;
    tick();
    check("pre_abort_src", src, 1'b1);

    // Reset during SHIFT cycle 6 aborts without ack.
    bin0 = 12'd4095; req = 2'b01;
    repeat (7) tick();
    check("abort_busy_before", busy, 1'b1);
    rst = 1'b1; req = 2'b00;
    tick();
    check("abort_ack", ack, 2'b00);
    check("abort_busy", busy, 1'b0);
    check("abort_src", src, 1'b0);
    check("abort_sel", digit_sel, 4'b1110);
    check("abort_val", digit_val, 4'h0);
    rst = 1'b0;
    seen_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack != 2'b00) seen_ack = 1'b1;
    end
    check("abort_no_ack", seen_ack, 1'b0);
    read_display("abort", LZB ? 16'hFFF0 : 16'h0000);

    // Scan order and slot length.
    n = 0;
    prev_sel = digit_sel;
    tick();
    while (!(digit_sel == 4'b1110 && prev_sel != 4'b1110) && n < 40) begin
      prev_sel = digit_sel;
      tick();
      n++;
    end
    check("scan_sync", digit_sel, 4'b1110);
    seq[0] = 4'b1101; seq[1] = 4'b1011; seq[2] = 4'b0111; seq[3] = 4'b1110;
    prev_sel = 4'b1110;
    for (int s = 0; s < 4; s++) begin
      repeat (3) tick();
      check($sformatf("scan_hold_%0d", s), digit_sel, prev_sel);
      tick();
      check($sformatf("scan_step_%0d", s), digit_sel, seq[s]);
      prev_sel = seq[s];
    end

    // Zero and interior zeros.
    bin0 = 12'd0; req = 2'b01;
    wait_ack("zero", 0, 2'b01);
    req = 2'b00;
    tick();
    read_display("zero", LZB ? 16'hFFF0 : 16'h0000);
    bin0 = 12'd1000; req = 2'b01;
    wait_ack("k1000", 0, 2'b01);
    req = 2'b00;
    tick();
    read_display("k1000", 16'h1000);

    // Request dropped at SHIFT cycle 3 still completes.
    bin0 = 12'd9; req = 2'b01;
    repeat (4) tick();
    req = 2'b00;
    wait_ack("drop", 4, 2'b01);
    tick();
    check("drop_busy_after", busy, 1'b0);
    check("drop_src", src, 1'b0);
    read_display("drop", LZB ? 16'hFFF9 : 16'h0009);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
